// File: rtl/receptor_pkg.sv
// Shared constants for the 8b/10b receptor: comma codes, FSM state encoding,
// word-width select encodings and the K28.5 byte value.
package receptor_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // K28.5 in both disparities, bit 9 = 'a' (first on the wire)
    localparam logic [9:0] K28_5_RDN  = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP  = 10'b1100000101;
    localparam logic [7:0] K28_5_BYTE = 8'hBC;

    // dataS word width select
    localparam logic [1:0] DS_W8     = 2'b00;
    localparam logic [1:0] DS_W16    = 2'b01;
    localparam logic [1:0] DS_W32    = 2'b10;
    localparam logic [1:0] DS_W8_ALT = 2'b11;

    // Index of the final byte of a word for a given width select
    function automatic logic [1:0] last_byte_idx(input logic [1:0] ds);
        case (ds)
            DS_W16:           return 2'd1;
            DS_W32:           return 2'd3;
            DS_W8, DS_W8_ALT: return 2'd0;
            default:          return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/receptor_decoder10_8.sv
// decoder10_8: combinational 10b -> 8b decode via 5b/6b and 3b/4b tables.
// Running disparity is not tracked; either disparity form of a code decodes.
//   symbol    in  [9:0] {a,b,c,d,e,i,f,g,h,j}, a in bit 9
//   data_byte out [7:0] HGFEDCBA
//   k_flag    out       symbol is a control (K) code
//   err_flag  out       symbol is not a legal code
module decoder10_8
    import receptor_pkg::*;
(
    input  logic [9:0] symbol,
    output logic [7:0] data_byte,
    output logic       k_flag,
    output logic       err_flag
);

    logic [5:0] code6;
    logic [3:0] code4;
    logic [3:0] k4;
    logic [4:0] edcba;
    logic [2:0] hgf;
    logic       err6, err4, is_k28, a7, k7, a7_data;

    assign code6 = symbol[9:4];
    assign code4 = symbol[3:0];
    // The two K28 6b forms are complements; normalise the 4b part to the
    // form that follows 110000 so one table covers both.
    assign k4    = (code6 == 6'b001111) ? ~code4 : code4;

    always_comb begin
        edcba  = 5'd0;
        err6   = 1'b0;
        is_k28 = 1'b0;
        case (code6)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110:            edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            6'b001111, 6'b110000: begin edcba = 5'd28; is_k28 = 1'b1; end
            default:              err6 = 1'b1;
        endcase
    end

    always_comb begin
        hgf  = 3'd0;
        err4 = 1'b0;
        a7   = 1'b0;
        if (is_k28) begin
            case (k4)
                4'b1011: hgf = 3'd0;
                4'b0110: hgf = 3'd1;
                4'b1010: hgf = 3'd2;
                4'b1100: hgf = 3'd3;
                4'b1101: hgf = 3'd4;
                4'b0101: hgf = 3'd5;
                4'b1001: hgf = 3'd6;
                4'b0111: hgf = 3'd7;
                default: err4 = 1'b1;
            endcase
        end else begin
            case (code4)
                4'b1011, 4'b0100: hgf = 3'd0;
                4'b1001:          hgf = 3'd1;
                4'b0101:          hgf = 3'd2;
                4'b1100, 4'b0011: hgf = 3'd3;
                4'b1101, 4'b0010: hgf = 3'd4;
                4'b1010:          hgf = 3'd5;
                4'b0110:          hgf = 3'd6;
                4'b1110, 4'b0001: hgf = 3'd7;
                4'b0111, 4'b1000: begin hgf = 3'd7; a7 = 1'b1; end
                default:          err4 = 1'b1;
            endcase
        end
    end

    // Alternate x.7 form: K23/27/29/30.7, or data only for the six
    // 5b values whose P7 form would create a run of five.
    assign k7      = a7 && (edcba == 5'd23 || edcba == 5'd27 ||
                            edcba == 5'd29 || edcba == 5'd30);
    assign a7_data = (edcba == 5'd11 || edcba == 5'd13 || edcba == 5'd14 ||
                      edcba == 5'd17 || edcba == 5'd18 || edcba == 5'd20);

    assign data_byte = {hgf, edcba};
    assign err_flag  = err6 | err4 | (a7 & ~k7 & ~a7_data);
    assign k_flag    = ~err_flag & (is_k28 | k7);

endmodule

// File: rtl/receptor.sv
// receptor: 8b/10b serial receiver with comma alignment and word assembly.
//   clk      in       bit-rate clock
//   rst      in       async active-low reset
//   enb      in       advance enable; low freezes everything
//   serialIn in       serial line, bit 'a' of each symbol first
//   dataS    in  [1:0] word width select (8/16/32/8)
//   dataOut  out [31:0] assembled word, first byte in [7:0]
//   valid    out      pulse when dataOut updates
//   kValid   out      pulse on a K symbol, kCode out [7:0] its value
//   locked   out      link in LOCKED
//   codeErr  out      pulse on an invalid symbol while LOCKED
module receptor
    import receptor_pkg::*;
#(
    parameter int LOCK_CNT  = 3,
    parameter int ERR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        serialIn,
    input  logic [1:0]  dataS,
    output logic [31:0] dataOut,
    output logic        valid,
    output logic        kValid,
    output logic [7:0]  kCode,
    output logic        locked,
    output logic        codeErr
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    state_e        state_q, state_d;
    // Nine bits of history; with the bit on the line they form the
    // 10-bit window that is decoded on the sampling edge.
    logic [8:0]    sr_q, sr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [1:0]    last_idx_q, last_idx_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   data_out_q, data_out_d;
    logic [7:0]    kcode_q, kcode_d;
    logic          valid_q, valid_d, kvalid_q, kvalid_d;
    logic          locked_q, locked_d, code_err_q, code_err_d;

    logic [9:0]    window;
    logic          is_comma;
    logic [7:0]    dec_byte;
    logic          dec_k, dec_err;
    logic [1:0]    last_idx;
    logic [31:0]   word_new;

    assign window   = {sr_q, serialIn};
    assign is_comma = (window == K28_5_RDN) || (window == K28_5_RDP);

    decoder10_8 u_dec (
        .symbol    (window),
        .data_byte (dec_byte),
        .k_flag    (dec_k),
        .err_flag  (dec_err)
    );

    // Width is captured with the first byte and held for the whole word
    assign last_idx = (byte_idx_q == 2'd0) ? last_byte_idx(dataS) : last_idx_q;
    assign word_new = ((byte_idx_q == 2'd0) ? 32'd0 : word_q)
                    | ({24'd0, dec_byte} << {byte_idx_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        byte_idx_d = byte_idx_q;
        last_idx_d = last_idx_q;
        word_d     = word_q;
        data_out_d = data_out_q;
        kcode_d    = kcode_q;
        valid_d    = valid_q;
        kvalid_d   = kvalid_q;
        code_err_d = code_err_q;
        locked_d   = locked_q;

        if (enb) begin
            sr_d       = window[8:0];
            valid_d    = 1'b0;
            kvalid_d   = 1'b0;
            code_err_d = 1'b0;

            if (state_q == ST_HUNT) begin
                if (is_comma) begin
                    state_d   = ST_CHECK;
                    bit_cnt_d = 4'd0;
                    kvalid_d  = 1'b1;
                    kcode_d   = K28_5_BYTE;
                end
            end else if (bit_cnt_q != 4'd9) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                // Symbol boundary: window holds a complete aligned symbol
                bit_cnt_d = 4'd0;
                if (dec_err) begin
                    byte_idx_d = 2'd0;
                    if (state_q == ST_CHECK) begin
                        state_d    = ST_HUNT;
                        good_cnt_d = '0;
                        err_cnt_d  = '0;
                    end else begin
                        code_err_d = 1'b1;
                        err_cnt_d  = err_cnt_q + EW'(1);
                        if (err_cnt_d == EW'(ERR_LIMIT)) begin
                            state_d    = ST_HUNT;
                            good_cnt_d = '0;
                            err_cnt_d  = '0;
                        end
                    end
                end else begin
                    if (state_q == ST_CHECK) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_d == GW'(LOCK_CNT)) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = '0;
                        end
                    end else begin
                        err_cnt_d = '0;
                    end

                    if (dec_k) begin
                        kvalid_d = 1'b1;
                        kcode_d  = dec_byte;
                        if (dec_byte == K28_5_BYTE)
                            byte_idx_d = 2'd0;
                    end else begin
                        if (byte_idx_q == 2'd0)
                            last_idx_d = last_idx;
                        if (byte_idx_q == last_idx) begin
                            data_out_d = word_new;
                            valid_d    = 1'b1;
                            byte_idx_d = 2'd0;
                        end else begin
                            word_d     = word_new;
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
            end
            locked_d = (state_d == ST_LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
            byte_idx_q <= '0;
            last_idx_q <= '0;
            word_q     <= '0;
            data_out_q <= '0;
            kcode_q    <= '0;
            valid_q    <= 1'b0;
            kvalid_q   <= 1'b0;
            code_err_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
            byte_idx_q <= byte_idx_d;
            last_idx_q <= last_idx_d;
            word_q     <= word_d;
            data_out_q <= data_out_d;
            kcode_q    <= kcode_d;
            valid_q    <= valid_d;
            kvalid_q   <= kvalid_d;
            code_err_q <= code_err_d;
            locked_q   <= locked_d;
        end
    end

    assign dataOut = data_out_q;
    assign valid   = valid_q;
    assign kValid  = kvalid_q;
    assign kCode   = kcode_q;
    assign locked  = locked_q;
    assign codeErr = code_err_q;

endmodule

// File: tb/tb_receptor.sv
// Directed bench for receptor: lock, word widths, K handling, code errors,
// enable stall and mid-word reset.
module tb_receptor;

    logic        clk = 1'b0;
    logic        rst, enb, serialIn;
    logic [1:0]  dataS;
    logic [31:0] dataOut;
    logic        valid, kValid, locked, codeErr;
    logic [7:0]  kCode;

    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] D000 = 10'b1001110100;
    localparam logic [9:0] BAD  = 10'b0000000000;

    int errors = 0;
    int checks = 0;
    int n_valid, n_kvalid, n_cerr;
    logic [31:0] last_data;

    receptor #(.LOCK_CNT(3), .ERR_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .enb(enb), .serialIn(serialIn), .dataS(dataS),
        .dataOut(dataOut), .valid(valid), .kValid(kValid), .kCode(kCode),
        .locked(locked), .codeErr(codeErr)
    );

    always #5 clk = ~clk;

    task automatic clr_counts();
        n_valid = 0; n_kvalid = 0; n_cerr = 0; last_data = 32'hDEADBEEF;
    endtask

    task automatic send_bit(input logic b);
        serialIn = b;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin n_valid++; last_data = dataOut; end
        if (kValid === 1'b1) n_kvalid++;
        if (codeErr === 1'b1) n_cerr++;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b0; enb = 1'b1; serialIn = 1'b0; dataS = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (kValid !== 1'b0)   begin errors++; $display("FAIL reset_kValid: got %b want 0", kValid); end
        checks++; if (kCode !== 8'd0)    begin errors++; $display("FAIL reset_kCode: got %h want 0", kCode); end
        checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (codeErr !== 1'b0)  begin errors++; $display("FAIL reset_codeErr: got %b want 0", codeErr); end
        rst = 1'b1;
        send_sym(BAD);
    endtask

    task automatic test_lock();
        dataS = 2'b00;
        clr_counts();
        send_sym(K285);
        checks++; if (kValid !== 1'b1)  begin errors++; $display("FAIL comma_kValid: got %b want 1", kValid); end
        checks++; if (kCode !== 8'hBC)  begin errors++; $display("FAIL comma_kCode: got %h want bc", kCode); end
        send_sym(D215);
        send_sym(D215);
        checks++; if (locked !== 1'b0)  begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
        send_sym(D215);
        checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL lock_third: got %b want 1", locked); end
        clr_counts();
        send_sym(D215);
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL w8_valid: got %b want 1", valid); end
        checks++; if (dataOut !== 32'h000000B5) begin errors++; $display("FAIL w8_data: got %h want 000000b5", dataOut); end
        send_sym(D215);
        checks++; if (n_valid !== 2)    begin errors++; $display("FAIL w8_count: got %0d want 2", n_valid); end
    endtask

    task automatic test_word32();
        dataS = 2'b10;
        clr_counts();
        send_sym(D000);
        send_sym(D215);
        send_sym(D215);
        checks++; if (n_valid !== 0)    begin errors++; $display("FAIL w32_early: got %0d want 0", n_valid); end
        send_sym(D215);
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL w32_valid: got %b want 1", valid); end
        checks++; if (dataOut !== 32'hB5B5B500) begin errors++; $display("FAIL w32_data: got %h want b5b5b500", dataOut); end
    endtask

    task automatic test_k_discard();
        dataS = 2'b01;
        clr_counts();
        send_sym(D215);
        send_sym(K285);
        checks++; if (kValid !== 1'b1)  begin errors++; $display("FAIL kd_kValid: got %b want 1", kValid); end
        send_sym(D000);
        send_sym(D215);
        checks++; if (n_valid !== 1)    begin errors++; $display("FAIL kd_count: got %0d want 1", n_valid); end
        checks++; if (last_data !== 32'h0000B500) begin errors++; $display("FAIL kd_data: got %h want 0000b500", last_data); end
    endtask

    task automatic test_enb_stall();
        dataS = 2'b00;
        clr_counts();
        for (int i = 9; i >= 5; i--) send_bit(D000[i]);
        enb = 1'b0;
        for (int c = 0; c < 7; c++) begin
            serialIn = c[0];
            @(posedge clk);
            #1;
            if (valid === 1'b1) n_valid++;
        end
        checks++; if (n_valid !== 0)    begin errors++; $display("FAIL stall_valid: got %0d want 0", n_valid); end
        checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL stall_locked: got %b want 1", locked); end
        enb = 1'b1;
        for (int i = 4; i >= 0; i--) send_bit(D000[i]);
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL stall_resume: got %b want 1", valid); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL stall_data: got %h want 0", dataOut); end
        send_sym(D215);
        checks++; if (dataOut !== 32'hB5 || valid !== 1'b1) begin errors++; $display("FAIL stall_next: got %h/%b want b5/1", dataOut, valid); end
    endtask

    task automatic test_code_err();
        clr_counts();
        for (int n = 1; n <= 4; n++) begin
            send_sym(BAD);
            checks++; if (codeErr !== 1'b1) begin errors++; $display("FAIL cerr_pulse%0d: got %b want 1", n, codeErr); end
            checks++; if (locked !== (n < 4)) begin errors++; $display("FAIL cerr_locked%0d: got %b want %b", n, locked, n < 4); end
        end
        checks++; if (n_cerr !== 4)     begin errors++; $display("FAIL cerr_count: got %0d want 4", n_cerr); end
        checks++; if (dataOut !== 32'hB5) begin errors++; $display("FAIL cerr_hold: got %h want b5", dataOut); end
    endtask

    task automatic test_reset_mid();
        dataS = 2'b00;
        send_sym(K285);
        repeat (3) send_sym(D215);
        checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL rm_relock: got %b want 1", locked); end
        dataS = 2'b10;
        send_sym(D215);
        send_sym(D215);
        for (int i = 9; i >= 5; i--) send_bit(D000[i]);
        rst = 1'b0;
        #1;
        checks++; if (dataOut !== 32'd0 || kCode !== 8'd0 || locked !== 1'b0 || valid !== 1'b0)
            begin errors++; $display("FAIL rm_zero: data=%h k=%h lock=%b v=%b want all 0", dataOut, kCode, locked, valid); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clr_counts();
        repeat (4) send_sym(D215);
        checks++; if (n_valid !== 0 || n_kvalid !== 0 || locked !== 1'b0)
            begin errors++; $display("FAIL rm_nocomma: v=%0d k=%0d lock=%b want 0/0/0", n_valid, n_kvalid, locked); end
        dataS = 2'b00;
        send_sym(K285);
        repeat (3) send_sym(D215);
        checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL rm_lock2: got %b want 1", locked); end
        send_sym(D215);
        checks++; if (valid !== 1'b1 || dataOut !== 32'hB5) begin errors++; $display("FAIL rm_data: got %b/%h want 1/b5", valid, dataOut); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_word32();
        test_k_discard();
        test_enb_stall();
        test_code_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receptor.md
RECEPTOR -- requirements
Module: receptor

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3, consecutive valid symbols needed in CHECK to enter LOCKED.
REQ-002 SHALL have parameter ERR_LIMIT, default 4, consecutive invalid symbols in LOCKED that force HUNT.
REQ-003 SHALL have one clock and reset: clk input 1, bit-rate clock, all logic on rising edge.
REQ-004 SHALL have rst input 1, asynchronous, active-low reset.
REQ-005 SHALL have enb input 1, advance enable: when low, all state and outputs hold and serialIn is ignored.
REQ-006 SHALL have serialIn input 1, 8b/10b serial line, one bit per enabled clk.
REQ-007 SHALL have dataS input 2, word width select: 00=8, 01=16, 10=32, 11=8.
REQ-008 SHALL have dataOut output 32, assembled word, unused upper bytes zero.
REQ-009 SHALL have valid output 1, one-clk pulse when dataOut is updated.
REQ-010 SHALL have kValid output 1, one-clk pulse on receipt of a control (K) symbol.
REQ-011 SHALL have kCode output 8, decoded K symbol value, updated with kValid.
REQ-012 SHALL have locked output 1, high in LOCKED state.
REQ-013 SHALL have codeErr output 1, one-clk pulse on an invalid 10-bit symbol while aligned.

Function
REQ-014 SHALL treat symbols as {a,b,c,d,e,i,f,g,h,j} in bits [9:0], bit 9 (a) received first; decoded byte is HGFEDCBA.
REQ-015 SHALL shift serialIn into a 10-bit shift register on every enabled clk.
REQ-016 SHALL run states HUNT, CHECK, LOCKED.
REQ-017 HUNT: on shift register equal to K28.5 (0011111010 or 1100000101), zero bit counter, go to CHECK; comma is reported as K (kValid, kCode=0xBC).
REQ-018 CHECK: every 10th bit, decode; valid symbol increments good count, reaching LOCK_CNT goes LOCKED; any invalid symbol returns to HUNT with no codeErr.
REQ-019 LOCKED: invalid symbol pulses codeErr and increments error count; valid symbol clears it; error count reaching ERR_LIMIT returns to HUNT.
REQ-020 SHALL ignore commas appearing at non-boundary bit positions in CHECK and LOCKED.
REQ-021 SHALL decode via 5b/6b and 3b/4b tables; running disparity SHALL NOT be checked.
REQ-022 In CHECK and LOCKED, data (D) symbols SHALL be placed at byte index n of the word, first byte in dataOut[7:0], index incrementing.
REQ-023 SHALL sample dataS only when byte index is 0; width change mid-word takes effect at next word.
REQ-024 SHALL assert valid and update dataOut on the clk after the last bit of the word's final symbol is sampled (latency 1 clk).
REQ-025 K symbols SHALL NOT enter the word; K28.5 SHALL clear byte index, discarding any partial word; other K symbols leave byte index unchanged.
REQ-026 Invalid symbols SHALL NOT enter the word and SHALL clear byte index.
REQ-027 Leaving LOCKED or CHECK for HUNT SHALL clear byte index and all counters; dataOut holds its last value.

Reset
REQ-028 On rst low: state HUNT, shift register, counters, byte index, dataOut, kCode zero; valid, kValid, codeErr, locked low.
REQ-029 Reset asserted mid-symbol or mid-word SHALL discard all partial data; first post-reset output requires fresh comma.

Structure
REQ-030 K28.5 codes, state encodings, dataS encodings and K28.5 byte value 0xBC SHALL live in a shared constants package/header.
REQ-031 10b-to-8b decode SHALL be one combinational sub-module, decoder10_8 (inputs symbol; outputs byte, K flag, error flag).

Verification
REQ-032 Reset, then K28.5, 3x D21.5 (1010101010), dataS=00 -> kValid with kCode=0xBC, locked high after third D21.5, valid pulses with dataOut=0x000000B5 per D symbol after lock.
REQ-033 Locked, dataS=10, D0.0 (1001110100), D21.5 x3 -> one valid, dataOut=0xB5B5B500.
REQ-034 Locked, dataS=01, D21.5, K28.5, D0.0, D21.5 -> first byte discarded, one valid with dataOut=0x0000B500.
REQ-035 Locked, 4 consecutive 0000000000 symbols -> codeErr pulses 4x, locked falls after fourth.
REQ-036 enb low for 7 clks mid-symbol then high -> same outputs as uninterrupted stream, delayed 7 clks.
REQ-037 rst low during a 32-bit word -> all outputs zero, no valid until new K28.5 and LOCK_CNT symbols.
